read_only_flash: RTL and testbench

//  Streaming read-only SPI NOR flash controller (mode 0, single-bit I/O, standard READ 0x03).
//  On rd pulse: assert chip select, send command + 24-bit address, then stream bytes out on q until halt_rd.

---
 rtl/read_only_flash_pkg.sv | 31 +++
 rtl/read_only_flash_spi_shift_phase.sv | 62 ++++++
 rtl/read_only_flash.sv | 141 ++++++++++++++
 tb/tb_read_only_flash.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/read_only_flash_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | read_only_flash_pkg                                                         |
// | Shared types and constants for the streaming SPI NOR read controller.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package read_only_flash_pkg;

    localparam int         ADDR_BITS        = 24;
    localparam int         CMD_BITS         = 8;
    localparam int         DATA_BITS        = 8;
    localparam int         WORD_BITS        = CMD_BITS + ADDR_BITS;
    localparam int         CNT_W            = 6;
    localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    // States in which the SPI clock toggles.
    function automatic logic is_clocking(input state_t s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/read_only_flash_spi_shift_phase.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_shift_phase                                                             |
// | clk/2 SPI clock phase generator with transmit and receive shift registers.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module spi_shift_phase #(
    parameter int WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WORD_BITS-1:0] load_word,
    input  logic                 run,
    input  logic                 so,
    output logic                 phase,
    output logic                 sample,
    output logic                 tx_bit,
    output logic [7:0]           rx_next
);

    logic [WORD_BITS-1:0] tx;
    logic [7:0]           rx;

    assign sample  = run & phase;
    assign tx_bit  = tx[WORD_BITS-1];
    assign rx_next = {rx[6:0], so};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
        end else if (run) begin
            phase <= ~phase;
        end else begin
            phase <= 1'b0;
        end
    end

    // Shifting on the edge that ends the high phase presents the next bit for the whole low phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx <= '0;
        end else if (load) begin
            tx <= load_word;
        end else if (sample) begin
            tx <= {tx[WORD_BITS-2:0], 1'b0};
        end
    end

    // Dropping run discards any partially received byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx <= '0;
        end else if (!run) begin
            rx <= '0;
        end else if (sample) begin
            rx <= rx_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/read_only_flash.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | read_only_flash                                                             |
// | Streaming SPI NOR reader: READ opcode + 24-bit address, then bytes to halt. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module read_only_flash
    import read_only_flash_pkg::*;
#(
    parameter logic [7:0] READ_CMD = READ_CMD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 rd,
    input  logic                 halt_rd,
    output logic [7:0]           q,
    output logic                 q_valid,
    output logic                 busy,
    output logic                 flash_cs_n,
    output logic                 flash_sck,
    output logic                 flash_si,
    input  logic                 flash_so
);

    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic             emit;
    logic             load;
    logic             run;
    logic             phase;
    logic             sample;
    logic             tx_bit;
    logic [7:0]       rx_next;

    assign load = (state == ST_IDLE) && rd && !halt_rd;
    assign run  = is_clocking(state);

    spi_shift_phase #(
        .WORD_BITS (WORD_BITS)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_word ({READ_CMD, addr}),
        .run       (run),
        .so        (flash_so),
        .phase     (phase),
        .sample    (sample),
        .tx_bit    (tx_bit),
        .rx_next   (rx_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            q       <= 8'h00;
            q_valid <= 1'b0;
        end else begin
            state   <= next_state;
            bit_cnt <= bit_cnt_next;
            q_valid <= emit;
            if (emit) begin
                q <= rx_next;
            end
        end
    end

    always_comb begin
        next_state   = state;
        bit_cnt_next = bit_cnt;
        emit         = 1'b0;
        case (state)
            ST_IDLE: begin
                bit_cnt_next = '0;
                if (load) begin
                    next_state = ST_START;
                end
            end
            ST_START: next_state = ST_CMD;
            ST_CMD: begin
                if (sample) begin
                    if (bit_cnt == CMD_LAST) begin
                        next_state   = ST_ADDR;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (sample) begin
                    if (bit_cnt == ADDR_LAST) begin
                        next_state   = ST_DATA;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_next = '0;
                        emit         = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                next_state   = ST_IDLE;
                bit_cnt_next = '0;
            end
            default: begin
                next_state   = ST_IDLE;
                bit_cnt_next = '0;
            end
        endcase
        // A halt coinciding with a byte boundary suppresses that byte too.
        if (halt_rd && (state != ST_IDLE) && (state != ST_STOP)) begin
            next_state   = ST_STOP;
            bit_cnt_next = '0;
            emit         = 1'b0;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign flash_cs_n = (state == ST_IDLE) || (state == ST_STOP);
    assign flash_sck  = run & phase;
    assign flash_si   = ((state == ST_START) || (state == ST_CMD) || (state == ST_ADDR)) ? tx_bit : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_read_only_flash.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_read_only_flash                                                          |
// | Bench with a bit-level SPI flash model driving table and random reads.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_read_only_flash;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] addr;
    logic        rd;
    logic        halt_rd;
    logic [7:0]  q;
    logic        q_valid;
    logic        busy;
    logic        flash_cs_n;
    logic        flash_sck;
    logic        flash_si;
    logic        flash_so = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    read_only_flash dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .rd         (rd),
        .halt_rd    (halt_rd),
        .q          (q),
        .q_valid    (q_valid),
        .busy       (busy),
        .flash_cs_n (flash_cs_n),
        .flash_sck  (flash_sck),
        .flash_si   (flash_si),
        .flash_so   (flash_so)
    );

    always #5 clk = ~clk;

    // Flash model: captures 32 bits on sck-high, then serves so_bits MSB-first (1s once exhausted).
    bit          so_bits[$];
    logic [7:0]  exp_bytes[$];
    logic [7:0]  got_q[$];
    int          rx_cnt      = 0;
    int          sptr        = 0;
    int          sck_pulses  = 0;
    int          viol        = 0;
    logic [31:0] cap_word    = '0;

    always @(negedge clk) begin
        if (flash_cs_n === 1'b1) begin
            rx_cnt     = 0;
            sptr       = 0;
            sck_pulses = 0;
            cap_word   = '0;
            flash_so   = 1'b0;
            if (flash_sck !== 1'b0) viol++;
        end else if (flash_sck === 1'b1) begin
            sck_pulses++;
            if (rx_cnt < 32) begin
                cap_word = {cap_word[30:0], flash_si};
                rx_cnt++;
            end else begin
                flash_so = (sptr < so_bits.size()) ? so_bits[sptr] : 1'b1;
                sptr++;
            end
        end else if (rx_cnt == 32 && flash_si !== 1'b0) begin
            viol++;
        end
    end

    always @(negedge clk) begin
        if (q_valid === 1'b1) got_q.push_back(q);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_txn(input logic [23:0] a, input logic [31:0] exp_cmd, input int extra,
                           input bit rd_mid, input bit probe);
        int          n;
        int          cyc;
        int          limit;
        int          v0;
        bit          mid_done;
        logic [31:0] cmd_seen;
        n = exp_bytes.size();
        so_bits.delete();
        foreach (exp_bytes[i]) for (int b = 7; b >= 0; b--) so_bits.push_back(exp_bytes[i][b]);
        got_q.delete();
        v0       = viol;
        mid_done = 1'b0;
        cyc      = 0;
        limit    = 120 + n * 20;
        addr = a; rd = 1'b1;
        tick(1);
        rd = 1'b0; addr = 24'($urandom);
        while (got_q.size() < n && cyc < limit) begin
            rd = rd_mid && !mid_done && (got_q.size() == 1);
            if (rd) mid_done = 1'b1;
            tick(1);
            cyc++;
            rd = 1'b0;
            if (probe && cyc == 65) begin
                check("state_after_addr", 3'(dut.state), 3'd4);
                check("sck_pulses_hdr", sck_pulses, 32);
                check("hdr_bits_early", cap_word, exp_cmd);
            end
        end
        if (got_q.size() < n) check("byte_timeout", got_q.size(), n);
        cmd_seen = cap_word;
        repeat (2 * extra) tick(1);
        halt_rd = 1'b1;
        tick(1);
        halt_rd = 1'b0;
        check("stop_state", {3'(dut.state), flash_cs_n, flash_sck, busy}, {3'd5, 1'b1, 1'b0, 1'b1});
        tick(1);
        check("idle_after_stop", {3'(dut.state), flash_cs_n, flash_sck, busy}, {3'd0, 1'b1, 1'b0, 1'b0});
        check("cmd_word", cmd_seen, exp_cmd);
        check("byte_count", got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) check("byte", got_q[i], exp_bytes[i]);
        if (n > 0) check("q_hold", q, exp_bytes[n-1]);
        check("pin_rules", viol - v0, 0);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [39:0] data;
        int          nbytes;
        int          extra;
        bit          rd_mid;
        logic [31:0] exp_cmd;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{24'hF0_1893, 40'hE2_A3_B6_F0_69, 5, 3, 1'b0, 32'h03F0_1893};
        vecs[1] = '{24'h00_0000, 40'h00_00_00_00_FF, 2, 0, 1'b1, 32'h0300_0000};
        vecs[2] = '{24'hFF_FFFF, 40'h00_00_00_00_5A, 1, 7, 1'b0, 32'h03FF_FFFF};
        vecs[3] = '{24'h12_3456, 40'h00_80_01_C3_7E, 4, 5, 1'b1, 32'h0312_3456};

        reset = 1'b1; rd = 1'b0; halt_rd = 1'b0; addr = '0;
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("reset_idle", {flash_cs_n, flash_sck, q, q_valid, busy},
                  {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
            tick(1);
        end

        foreach (vecs[v]) begin
            exp_bytes.delete();
            for (int i = 0; i < vecs[v].nbytes; i++)
                exp_bytes.push_back(vecs[v].data[8*(vecs[v].nbytes-1-i) +: 8]);
            run_txn(vecs[v].addr, vecs[v].exp_cmd, vecs[v].extra, vecs[v].rd_mid, v == 0);
        end

        // rd together with halt_rd in IDLE must not start a transfer.
        rd = 1'b1; halt_rd = 1'b1; addr = 24'h55_AA55;
        tick(1);
        rd = 1'b0; halt_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rd_halt_idle", {busy, flash_cs_n}, 2'b01);
            tick(1);
        end

        // Asynchronous reset in the middle of the address phase.
        got_q.delete();
        addr = 24'hAB_CDEF; rd = 1'b1;
        tick(1);
        rd = 1'b0;
        tick(30);
        check("in_addr_phase", 3'(dut.state), 3'd3);
        #2 reset = 1'b1;
        #1;
        check("async_reset", {flash_cs_n, flash_sck, busy, 3'(dut.state), q, q_valid},
              {1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0});
        tick(1);
        reset = 1'b0;
        tick(2);
        check("no_partial_byte", got_q.size(), 0);
        exp_bytes.delete();
        exp_bytes.push_back(8'h3C);
        run_txn(24'hAB_CDEF, 32'h03AB_CDEF, 2, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            logic [23:0] ra;
            int          nb;
            ra = 24'($urandom);
            nb = int'($urandom_range(1, 4));
            exp_bytes.delete();
            for (int i = 0; i < nb; i++) exp_bytes.push_back(8'($urandom));
            run_txn(ra, {8'h03, ra}, int'($urandom_range(0, 7)),
                    (nb >= 2) && ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
